// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared width helpers for the width-converting FIFO controller
package fifo_ctrl_pkg;

  // Lane-select width: one bit minimum so RATIO=1 still has a legal port.
  function automatic int lane_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Pointers and occupancy carry one extra wrap bit over the address.
  function automatic int occ_w(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_lane_ctr.sv
// rtl/fifo_lane_ctr.sv - read-side lane counter with physical lane mapping and last-lane flag
module fifo_lane_ctr
  import fifo_ctrl_pkg::*;
#(
  parameter int RATIO     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clr,
  input  logic                      adv,
  output logic [lane_w(RATIO)-1:0]  lane,
  output logic                      last_lane
);

  localparam int LW = lane_w(RATIO);

  logic [LW-1:0] idx;

  // RATIO is a power of two, so the counter wraps to 0 by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (adv) begin
      idx <= (RATIO == 1) ? '0 : idx + 1'b1;
    end
  end

  // With RATIO = 2**LW, RATIO-1-idx is simply the bitwise inverse of idx.
  assign lane      = (RATIO == 1) ? '0 : (MSB_FIRST ? ~idx : idx);
  assign last_lane = (RATIO == 1) || (idx == LW'(RATIO - 1));

endmodule

// File: rtl/fifo_ctrl_wc.sv
// rtl/fifo_ctrl_wc.sv - width-converting circular-queue controller (wide write, per-lane read)
module fifo_ctrl_wc
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int RATIO      = 2,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          rd,
  input  logic                          wr,
  output logic [ADDR_WIDTH-1:0]         w_addr,
  output logic [ADDR_WIDTH-1:0]         r_addr,
  output logic [lane_w(RATIO)-1:0]      r_lane,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [occ_w(ADDR_WIDTH)-1:0]  count,
  output logic                          wr_err,
  output logic                          rd_err
);

  localparam int CW    = occ_w(ADDR_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [CW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] wr_ptr_n, rd_ptr_n, count_n;
  logic          wr_acc, rd_acc, retire, last_lane;

  // Requests are judged against the registered flags only, so no bypass.
  always_comb begin
    wr_acc   = wr && !full;
    rd_acc   = rd && !empty;
    retire   = rd_acc && last_lane;
    wr_ptr_n = wr_ptr + CW'(wr_acc);
    rd_ptr_n = rd_ptr + CW'(retire);
    count_n  = wr_ptr_n - rd_ptr_n;
  end

  fifo_lane_ctr #(
    .RATIO     (RATIO),
    .MSB_FIRST (MSB_FIRST)
  ) u_lane (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (flush),
    .adv       (rd_acc && !flush),
    .lane      (r_lane),
    .last_lane (last_lane)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      wr_err       <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      count        <= count_n;
      empty        <= (count_n == '0);
      full         <= (count_n == CW'(DEPTH));
      almost_empty <= (count_n <= CW'(AE_LEVEL));
      almost_full  <= (count_n >= CW'(AF_LEVEL));
      wr_err       <= wr && full;
      rd_err       <= rd && empty;
    end
  end

  assign w_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign r_addr = rd_ptr[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_ctrl_wc.sv
// tb/tb_fifo_ctrl_wc.sv - self-checking bench for fifo_ctrl_wc with a word/lane queue model
module tb_fifo_ctrl_wc;

  localparam int AW    = 2;
  localparam int RATIO = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [1:0] w_addr, r_addr;
  logic [0:0] r_lane;
  logic       empty, full, almost_empty, almost_full, wr_err, rd_err;
  logic [2:0] count;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: words held, reads done on the head word, slot indices.
  int m_count, m_lane, m_wa, m_ra;
  bit m_werr, m_rerr;

  fifo_ctrl_wc #(
    .ADDR_WIDTH (AW),
    .RATIO      (RATIO),
    .MSB_FIRST  (1'b1),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .rd           (rd),
    .wr           (wr),
    .w_addr       (w_addr),
    .r_addr       (r_addr),
    .r_lane       (r_lane),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .wr_err       (wr_err),
    .rd_err       (rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || flush) begin
      m_count = 0; m_lane = 0; m_wa = 0; m_ra = 0; m_werr = 0; m_rerr = 0;
    end else begin
      bit wacc, racc;
      wacc   = wr && (m_count < DEPTH);
      racc   = rd && (m_count > 0);
      m_werr = wr && (m_count == DEPTH);
      m_rerr = rd && (m_count == 0);
      if (racc) begin
        if (m_lane == RATIO - 1) begin
          m_lane  = 0;
          m_ra    = (m_ra + 1) % DEPTH;
          m_count = m_count - 1;
        end else begin
          m_lane = m_lane + 1;
        end
      end
      if (wacc) begin
        m_wa    = (m_wa + 1) % DEPTH;
        m_count = m_count + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("count",        int'(count),        m_count);
      chk("empty",        int'(empty),        int'(m_count == 0));
      chk("full",         int'(full),         int'(m_count == DEPTH));
      chk("almost_full",  int'(almost_full),  int'(m_count >= AF));
      chk("almost_empty", int'(almost_empty), int'(m_count <= AE));
      chk("w_addr",       int'(w_addr),       m_wa);
      chk("r_addr",       int'(r_addr),       m_ra);
      chk("r_lane",       int'(r_lane),       RATIO - 1 - m_lane);
      chk("wr_err",       int'(wr_err),       int'(m_werr));
      chk("rd_err",       int'(rd_err),       int'(m_rerr));
    end
  end

  task automatic step(input logic r, input logic w, input logic f);
    rd = r; wr = w; flush = f;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0; flush = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_empty",  int'(empty),  1);
    chk("rst_r_lane", int'(r_lane), 1);
    chk("rst_count",  int'(count),  0);

    // 1: reset dropped between edges after some traffic
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("pre_rst_count", int'(count), 2);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count",  int'(count),  0);
    chk("arst_empty",  int'(empty),  1);
    chk("arst_r_lane", int'(r_lane), 1);
    chk("arst_w_addr", int'(w_addr), 0);
    chk("arst_ae",     int'(almost_empty), 1);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // 2: fill
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0);
      chk("fill_count", int'(count), i);
      chk("fill_af",    int'(almost_full), int'(i >= 3));
    end
    chk("fill_full",   int'(full),   1);
    chk("fill_w_addr", int'(w_addr), 0);
    step(0, 1, 0);
    chk("ovf_wr_err", int'(wr_err), 1);
    chk("ovf_count",  int'(count),  4);
    step(0, 0, 0);
    chk("ovf_wr_err_clr", int'(wr_err), 0);

    // 3: drain two lanes
    step(1, 0, 0);
    chk("drain1_r_lane", int'(r_lane), 0);
    chk("drain1_full",   int'(full),   1);
    step(1, 0, 0);
    chk("drain2_full",   int'(full),   0);
    chk("drain2_count",  int'(count),  3);
    chk("drain2_r_addr", int'(r_addr), 1);

    // 4: empty out, then simultaneous rd/wr on empty
    repeat (6) step(1, 0, 0);
    chk("emptied", int'(empty), 1);
    step(1, 1, 0);
    chk("sim_e_count",  int'(count),  1);
    chk("sim_e_empty",  int'(empty),  0);
    chk("sim_e_rd_err", int'(rd_err), 1);
    chk("sim_e_r_addr", int'(r_addr), 0);
    chk("sim_e_r_lane", int'(r_lane), 1);

    // 5: full with the head word on its last lane, simultaneous rd/wr
    repeat (3) step(0, 1, 0);
    step(1, 0, 0);
    chk("pre5_full",   int'(full),   1);
    chk("pre5_r_lane", int'(r_lane), 0);
    step(1, 1, 0);
    chk("sim_f_count",  int'(count),  3);
    chk("sim_f_wr_err", int'(wr_err), 1);
    chk("sim_f_w_addr", int'(w_addr), 0);
    chk("sim_f_r_addr", int'(r_addr), 1);

    // 6: flush with count=2, head word half read, rd/wr asserted
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("pre6_count", int'(count), 2);
    step(1, 1, 1);
    chk("flush_count",  int'(count),  0);
    chk("flush_empty",  int'(empty),  1);
    chk("flush_r_lane", int'(r_lane), 1);
    chk("flush_wr_err", int'(wr_err), 0);
    chk("flush_rd_err", int'(rd_err), 0);

    repeat (2) step(0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
